// File: rtl/freq_meter_if.sv
// Control and result bundle of a freq_meter: the driver side is master, the meter is slave.
interface freq_meter_if #(
  parameter int CNT_W = 32
);
  logic             sig_in;
  logic             start;
  logic             cont;
  logic [CNT_W-1:0] freq;
  logic             valid;
  logic             busy;
  logic             overflow;

  modport master (output sig_in, start, cont, input freq, valid, busy, overflow);
  modport slave  (input sig_in, start, cont, output freq, valid, busy, overflow);
endinterface

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over a window of
// exactly GATE_CYCLES clk cycles, optionally back-to-back, and reports the count.
module freq_meter #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int GATE_CYCLES = CLK_HZ,
  parameter int CNT_W       = 32
) (
  input logic         clk,
  input logic         reset,
  freq_meter_if.slave bus
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] LAST_TICK = GW'(GATE_CYCLES - 1);

  typedef enum logic {IDLE, GATE} state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             rise;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_nxt;
  logic             ovf_i, sat_hit, last;
  logic [CNT_W-1:0] freq_q;
  logic             valid_q, ovf_q;

  // The synchronizer runs in every state so a level already high at window start is not an edge.
  assign rise = s2 & ~s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    last      = 1'b0;
    edge_nxt  = edge_cnt;
    sat_hit   = 1'b0;
    if (rise) begin
      if (&edge_cnt) sat_hit  = 1'b1;
      else           edge_nxt = edge_cnt + CNT_W'(1);
    end
    case (state)
      IDLE: if (bus.start) state_nxt = GATE;
      GATE: begin
        if (gate_cnt == LAST_TICK) begin
          last = 1'b1;
          if (!bus.cont) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Closing a window clears the counters, so a cont window starts with no dead cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_i    <= 1'b0;
      freq_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      s1      <= bus.sig_in;
      s2      <= s1;
      s3      <= s2;
      valid_q <= 1'b0;
      if (state == IDLE) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        ovf_i    <= 1'b0;
      end else if (last) begin
        freq_q   <= edge_nxt;
        ovf_q    <= ovf_i | sat_hit;
        valid_q  <= 1'b1;
        gate_cnt <= '0;
        edge_cnt <= '0;
        ovf_i    <= 1'b0;
      end else begin
        gate_cnt <= gate_cnt + GW'(1);
        edge_cnt <= edge_nxt;
        ovf_i    <= ovf_i | sat_hit;
      end
    end
  end

  assign bus.freq     = freq_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = (state == GATE);
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: a 32-bit and a 4-bit meter share one stimulus signal,
// and every window count is recomputed from the recorded per-cycle samples of sig_in.
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int G = 100;

  logic clk;
  logic reset;
  logic sig;
  int   passed = 0;
  int   fails  = 0;
  int   total  = 0;
  int   cyc    = 0;
  logic samp [0:65535];

  int   gmode = 0;
  logic glevel = 1'b0;
  int   ghi = 2, glo = 2, gphase = 0, gen_req = 0;

  freq_meter_if #(.CNT_W(32)) b32 ();
  freq_meter_if #(.CNT_W(4))  b4 ();

  assign b32.sig_in = sig;
  assign b4.sig_in  = sig;

  freq_meter #(.CLK_HZ(50_000_000), .GATE_CYCLES(G), .CNT_W(32)) dut32 (
    .clk(clk), .reset(reset), .bus(b32.slave));
  freq_meter #(.CLK_HZ(50_000_000), .GATE_CYCLES(G), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4.slave));

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Sample record: samp[n] is the sig_in level captured at rising edge n.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      samp[cyc] = sig;
    end
  end

  // Stimulus generator: constant level, fixed period, or random high/low lengths of 2..9.
  initial begin
    int seen_req = -1;
    int cnt = 0, hi = 2, lo = 2;
    sig = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (gen_req != seen_req) begin
        seen_req = gen_req;
        cnt = gphase;
        hi = ghi;
        lo = glo;
      end
      if (gmode == 0) sig = glevel;
      else begin
        cnt++;
        if (sig && cnt >= hi) begin
          sig = 1'b0;
          cnt = 0;
          if (gmode == 2) lo = $urandom_range(2, 9);
        end else if (!sig && cnt >= lo) begin
          sig = 1'b1;
          cnt = 0;
          if (gmode == 2) hi = $urandom_range(2, 9);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, observed hang expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic set_sig(input int mode, input logic level, input int hi, input int lo);
    gmode  = mode;
    glevel = level;
    ghi    = hi;
    glo    = lo;
    gphase = $urandom_range(0, hi - 1);
    gen_req++;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: a window closing at edge vc spans cycles vc-G..vc-1, and a sampled rise at
  // edge m reaches the counter in cycle m+1 through the synchronizer.
  function automatic longint model_count(input int vc, input int w, output bit ovf);
    longint c;
    longint mx;
    c = 0;
    for (int n = vc - G; n < vc; n++)
      if (samp[n-1] && !samp[n-2]) c++;
    mx  = (longint'(1) << w) - 1;
    ovf = (c > mx);
    return ovf ? mx : c;
  endfunction

  task automatic win32(input string tag, input bit pulses, output int vc);
    int sc, busyn;
    bit seen, ovf;
    longint e;
    @(negedge clk);
    b32.start = 1'b1;
    sc = cyc + 1;
    @(negedge clk);
    b32.start = 1'b0;
    busyn = 0;
    seen = 0;
    vc = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      if (n > 0) @(negedge clk);
      if (b32.busy) busyn++;
      b32.start = pulses && b32.busy && (busyn % 17 == 5);
      if (b32.valid) begin
        seen = 1;
        vc = cyc;
      end
    end
    b32.start = 1'b0;
    check({tag, "/valid_seen"}, seen, 1);
    if (seen) begin
      check({tag, "/latency"}, vc, sc + G);
      check({tag, "/busy_cycles"}, busyn, G);
      e = model_count(vc, 32, ovf);
      check({tag, "/freq"}, b32.freq, e);
      check({tag, "/overflow"}, b32.overflow, ovf);
      @(negedge clk);
      check({tag, "/valid_width"}, b32.valid, 0);
    end
  endtask

  task automatic win4(input string tag, input longint exp_f, input bit exp_o);
    bit seen, ovf;
    int vc;
    longint e;
    @(negedge clk);
    b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    seen = 0;
    vc = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      if (n > 0) @(negedge clk);
      if (b4.valid) begin
        seen = 1;
        vc = cyc;
      end
    end
    check({tag, "/valid_seen"}, seen, 1);
    if (seen) begin
      e = model_count(vc, 4, ovf);
      check({tag, "/freq_model"}, b4.freq, e);
      check({tag, "/freq"}, b4.freq, exp_f);
      check({tag, "/overflow"}, b4.overflow, exp_o);
    end
  endtask

  task automatic wait_valid32(input int limit, output bit seen, output int vc, output int idle_n);
    seen = 0;
    vc = 0;
    idle_n = 0;
    for (int n = 0; n < limit && !seen; n++) begin
      @(negedge clk);
      if (!b32.busy) idle_n++;
      if (b32.valid) begin
        seen = 1;
        vc = cyc;
      end
    end
  endtask

  initial begin
    int vc, sc, idle_n, cnt;
    bit seen, ovf;
    b32.start = 1'b0;
    b32.cont  = 1'b0;
    b4.start  = 1'b0;
    b4.cont   = 1'b0;
    reset     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/freq", b32.freq, 0);
    check("reset/valid", b32.valid, 0);
    check("reset/busy", b32.busy, 0);
    check("reset/overflow", b32.overflow, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] period-10 input, single window");
    set_sig(1, 1'b0, 5, 5);
    repeat (5) @(negedge clk);
    win32("t1", 0, vc);
    check("t1/freq_range", (b32.freq >= 9 && b32.freq <= 11), 1);

    $display("[TB] random high/low lengths");
    for (int k = 0; k < 3; k++) begin
      set_sig(2, 1'b0, $urandom_range(2, 9), $urandom_range(2, 9));
      repeat ($urandom_range(3, 12)) @(negedge clk);
      win32("rnd", 0, vc);
    end

    $display("[TB] constant input levels");
    set_sig(0, 1'b1, 2, 2);
    repeat (5) @(negedge clk);
    win32("t2_high", 0, vc);
    check("t2_high/zero", b32.freq, 0);
    set_sig(0, 1'b0, 2, 2);
    repeat (5) @(negedge clk);
    win32("t2_low", 0, vc);
    check("t2_low/zero", b32.freq, 0);

    $display("[TB] 4-bit counter saturation");
    set_sig(1, 1'b0, 2, 2);
    repeat (5) @(negedge clk);
    win4("t3_sat", 15, 1'b1);
    set_sig(1, 1'b0, 10, 10);
    repeat (25) @(negedge clk);
    win4("t3_norm", 5, 1'b0);

    $display("[TB] continuous mode");
    set_sig(1, 1'b0, 2, 3);
    repeat (5) @(negedge clk);
    b32.cont = 1'b1;
    @(negedge clk);
    b32.start = 1'b1;
    sc = cyc + 1;
    @(negedge clk);
    b32.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_valid32(G + 10, seen, vc, idle_n);
      check("t4/valid_seen", seen, 1);
      check("t4/period", vc, sc + G * (k + 1));
      check("t4/freq", b32.freq, 20);
      check("t4/freq_model", b32.freq, model_count(vc, 32, ovf));
      check("t4/busy_gaps", idle_n, 0);
      check("t4/busy_at_valid", b32.busy, 1);
    end
    repeat (30) @(negedge clk);
    b32.cont = 1'b0;
    wait_valid32(G + 10, seen, vc, idle_n);
    check("t4_stop/valid_seen", seen, 1);
    check("t4_stop/period", vc, sc + G * 4);
    check("t4_stop/freq", b32.freq, 20);
    @(negedge clk);
    check("t4_stop/idle", b32.busy, 0);
    wait_valid32(G + 20, seen, vc, idle_n);
    check("t4_stop/no_more_valid", seen, 0);

    $display("[TB] reset in the middle of a window");
    set_sig(1, 1'b0, 5, 5);
    repeat (5) @(negedge clk);
    b32.start = 1'b1;
    @(negedge clk);
    b32.start = 1'b0;
    repeat (50) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5/freq", b32.freq, 0);
    check("t5/valid", b32.valid, 0);
    check("t5/busy", b32.busy, 0);
    check("t5/overflow", b32.overflow, 0);
    cnt = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (b32.valid || b32.busy) cnt++;
    end
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check("t5/no_valid_after_abort", b32.valid | b32.busy, 0);
    check("t5/quiet_in_reset", cnt, 0);
    win32("t5_fresh", 0, vc);
    check("t5_fresh/freq", b32.freq, 10);

    $display("[TB] start pulses while busy");
    win32("t6", 1, vc);
    cnt = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (b32.valid || b32.busy) cnt++;
    end
    check("t6/no_retrigger", cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
